timer_ctrl: RTL and testbench



---
 rtl/timer_ctrl.sv | 84 ++++++++
 tb/tb_timer_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Programmable interval timer: prescaled up-counter with a terminal-count compare,
// one-shot or periodic reload, a done strobe and a sticky interrupt flag.
module timer_ctrl #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  periodic_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      period_i,
  input  logic                  irq_clr_i,
  output logic [WIDTH-1:0]      count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  irq_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]      COUNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE   = PRESCALE_W'(1);

  state_t                state_q;
  logic [PRESCALE_W-1:0] prescale_cnt_q;
  logic [PRESCALE_W-1:0] prescale_sh_q;
  logic [WIDTH-1:0]      period_sh_q;
  logic                  periodic_sh_q;

  // Configuration is taken into shadows only at start, so the live inputs may
  // change while running. A terminal-event irq set is written after the clear
  // so that the set wins on a shared edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      count_o        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      irq_o          <= 1'b0;
      prescale_cnt_q <= '0;
      prescale_sh_q  <= '0;
      period_sh_q    <= '0;
      periodic_sh_q  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (irq_clr_i) begin
        irq_o <= 1'b0;
      end
      if (stop_i) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end else if (start_i) begin
        state_q        <= RUN;
        busy_o         <= 1'b1;
        count_o        <= '0;
        prescale_cnt_q <= '0;
        prescale_sh_q  <= prescale_i;
        period_sh_q    <= period_i;
        periodic_sh_q  <= periodic_i;
      end else if (state_q == RUN) begin
        if (prescale_cnt_q == prescale_sh_q) begin
          prescale_cnt_q <= '0;
          if (count_o == period_sh_q) begin
            done_o <= 1'b1;
            irq_o  <= 1'b1;
            if (periodic_sh_q) begin
              count_o <= '0;
            end else begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
            end
          end else begin
            count_o <= count_o + COUNT_ONE;
          end
        end else begin
          prescale_cnt_q <= prescale_cnt_q + PRE_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, hand-written corner sequences
// and random stimulus compared against an elapsed-time arithmetic model.
module tb_timer_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i, stop_i, periodic_i, irq_clr_i;
  logic [7:0]  prescale_i;
  logic [15:0] period_i;
  logic [15:0] count_o;
  logic        busy_o, done_o, irq_o;

  int checks   = 0;
  int failures = 0;

  timer_ctrl #(.WIDTH(16), .PRESCALE_W(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .periodic_i (periodic_i),
    .prescale_i (prescale_i),
    .period_i   (period_i),
    .irq_clr_i  (irq_clr_i),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .irq_o      (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outputs derived from cycles elapsed since the start edge.
  longint cyc, e0, m_n, m_p;
  bit     m_run, m_per, m_done, m_irq;
  longint m_count;

  task automatic modelReset();
    m_run = 0; m_per = 0; m_done = 0; m_irq = 0; m_count = 0; m_n = 0; m_p = 0; e0 = 0;
  endtask

  task automatic modelEdge(input bit st, input bit sp, input bit per, input longint p,
                           input longint n, input bit clr);
    longint t, len;
    m_done = 0;
    if (sp) begin
      m_run = 0;
    end else if (st) begin
      m_run = 1; e0 = cyc; m_n = n; m_p = p; m_per = per; m_count = 0;
    end else if (m_run) begin
      t   = cyc - e0;
      len = (m_n + 1) * (m_p + 1);
      if (m_per) begin
        m_done  = (t % len) == 0;
        m_count = (t % len) / (m_p + 1);
      end else if (t == len) begin
        m_done = 1; m_run = 0; m_count = m_n;
      end else begin
        m_count = t / (m_p + 1);
      end
    end
    if (m_done) m_irq = 1;
    else if (clr) m_irq = 0;
  endtask

  task automatic checkVal(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".count"}, longint'(count_o), m_count);
    checkVal({tag, ".busy"},  longint'(busy_o),  longint'(m_run));
    checkVal({tag, ".done"},  longint'(done_o),  longint'(m_done));
    checkVal({tag, ".irq"},   longint'(irq_o),   longint'(m_irq));
  endtask

  // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
  task automatic applyStimulus(input bit st, input bit sp, input bit per, input logic [7:0] p,
                               input logic [15:0] n, input bit clr, input string tag);
    start_i = st; stop_i = sp; periodic_i = per; prescale_i = p; period_i = n; irq_clr_i = clr;
    @(posedge clk_i);
    cyc++;
    modelEdge(st, sp, per, longint'(p), longint'(n), clr);
    #1;
    checkOutput(tag);
  endtask

  typedef struct {
    bit          start, stop, periodic;
    logic [7:0]  p;
    logic [15:0] n;
    bit          clr;
    logic [15:0] exp_count;
    bit          exp_busy, exp_done, exp_irq;
  } vec_t;

  vec_t vecs[8];
  int   per_exp[12];

  initial begin
    vecs[0] = '{1, 0, 0, 8'd0, 16'd3, 0, 16'd0, 1, 0, 0};
    vecs[1] = '{0, 0, 0, 8'd0, 16'd3, 0, 16'd1, 1, 0, 0};
    vecs[2] = '{0, 0, 0, 8'd0, 16'd3, 0, 16'd2, 1, 0, 0};
    vecs[3] = '{0, 0, 0, 8'd0, 16'd3, 0, 16'd3, 1, 0, 0};
    vecs[4] = '{0, 0, 0, 8'd0, 16'd3, 0, 16'd3, 0, 1, 1};
    vecs[5] = '{0, 0, 0, 8'd0, 16'd3, 0, 16'd3, 0, 0, 1};
    vecs[6] = '{1, 1, 1, 8'd2, 16'd7, 0, 16'd3, 0, 0, 1};
    vecs[7] = '{0, 0, 0, 8'd0, 16'd3, 1, 16'd3, 0, 0, 0};
    per_exp = '{0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2, 0};

    cyc = 0;
    modelReset();
    reset_i = 1; start_i = 0; stop_i = 0; periodic_i = 0; prescale_i = 0; period_i = 0;
    irq_clr_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 0;
    checkVal("reset.count", longint'(count_o), 0);
    checkVal("reset.busy",  longint'(busy_o),  0);
    checkVal("reset.done",  longint'(done_o),  0);
    checkVal("reset.irq",   longint'(irq_o),   0);

    // One-shot N=3 P=0, stop beating start, then irq clear.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].periodic, vecs[i].p, vecs[i].n,
                    vecs[i].clr, $sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d.count_tbl", i), longint'(count_o), longint'(vecs[i].exp_count));
      checkVal($sformatf("vec%0d.busy_tbl", i),  longint'(busy_o),  longint'(vecs[i].exp_busy));
      checkVal($sformatf("vec%0d.done_tbl", i),  longint'(done_o),  longint'(vecs[i].exp_done));
      checkVal($sformatf("vec%0d.irq_tbl", i),   longint'(irq_o),   longint'(vecs[i].exp_irq));
    end

    // Periodic N=2 P=1; period_i changes to 9 mid-run without effect.
    applyStimulus(1, 0, 1, 8'd1, 16'd2, 0, "per.start");
    for (int t = 0; t < 12; t++) begin
      applyStimulus(0, 0, 0, 8'd1, (t >= 3) ? 16'd9 : 16'd2, 0, $sformatf("per.t%0d", t + 1));
      checkVal($sformatf("per.count_t%0d", t + 1), longint'(count_o), longint'(per_exp[t]));
      checkVal($sformatf("per.done_t%0d", t + 1), longint'(done_o), (t == 5 || t == 11) ? 1 : 0);
      checkVal($sformatf("per.busy_t%0d", t + 1), longint'(busy_o), 1);
    end

    // Stop at count 4, idle without done, then a full 11-cycle restart.
    applyStimulus(1, 0, 0, 8'd0, 16'd10, 1, "stop.start");
    repeat (4) applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "stop.run");
    applyStimulus(0, 1, 0, 8'd0, 16'd10, 0, "stop.stop");
    checkVal("stop.count_held", longint'(count_o), 4);
    checkVal("stop.busy_low", longint'(busy_o), 0);
    repeat (3) applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "stop.idle");
    applyStimulus(1, 0, 0, 8'd0, 16'd10, 0, "stop.restart");
    repeat (10) applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "stop.rerun");
    checkVal("stop.pre_done", longint'(done_o), 0);
    applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "stop.term");
    checkVal("stop.done_at_11", longint'(done_o), 1);
    checkVal("stop.count_n", longint'(count_o), 10);

    // irq clear, then clear coinciding with a terminal event.
    applyStimulus(0, 0, 0, 8'd0, 16'd0, 1, "irq.clr");
    checkVal("irq.cleared", longint'(irq_o), 0);
    applyStimulus(1, 0, 0, 8'd0, 16'd1, 0, "irq.start");
    applyStimulus(0, 0, 0, 8'd0, 16'd1, 0, "irq.run");
    applyStimulus(0, 0, 0, 8'd0, 16'd1, 1, "irq.term");
    checkVal("irq.set_wins", longint'(irq_o), 1);

    // N=0, P=0 periodic: terminal event every cycle.
    applyStimulus(1, 0, 1, 8'd0, 16'd0, 0, "n0.start");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 8'd0, 16'd0, 0, "n0.run");
      checkVal("n0.done", longint'(done_o), 1);
      checkVal("n0.count", longint'(count_o), 0);
    end

    // Asynchronous reset mid-cycle with count at 5.
    applyStimulus(1, 0, 0, 8'd0, 16'd10, 0, "rst.start");
    repeat (5) applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "rst.run");
    checkVal("rst.count5", longint'(count_o), 5);
    #2 reset_i = 1;
    #1;
    checkVal("rst.async_count", longint'(count_o), 0);
    checkVal("rst.async_busy",  longint'(busy_o),  0);
    checkVal("rst.async_done",  longint'(done_o),  0);
    checkVal("rst.async_irq",   longint'(irq_o),   0);
    @(posedge clk_i);
    #1 reset_i = 0;
    modelReset();
    applyStimulus(0, 0, 0, 8'd0, 16'd10, 0, "rst.idle");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom % 10) == 0, ($urandom % 16) == 0, 1'($urandom % 2),
                    8'($urandom % 4), 16'($urandom % 6), ($urandom % 8) == 0, "rnd");
    end

    // Full-width terminal count: one-shot N=0xFFFF, P=0.
    applyStimulus(1, 0, 0, 8'd0, 16'hFFFF, 1, "big.start");
    repeat (65535) applyStimulus(0, 0, 0, 8'd0, 16'hFFFF, 0, "big.run");
    checkVal("big.count_max", longint'(count_o), 65535);
    checkVal("big.no_done_yet", longint'(done_o), 0);
    applyStimulus(0, 0, 0, 8'd0, 16'hFFFF, 0, "big.term");
    checkVal("big.done", longint'(done_o), 1);
    checkVal("big.busy_low", longint'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
